// File: rtl/output_process_uart_pkg.sv
// Shared definitions for the UART output path: FSM encodings, byte order and the
// idle-gap length that the far-end receiver uses as its end-of-message timeout.
package output_process_uart_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_POP     = 3'd1;
   localparam logic [2:0] ST_LATCH   = 3'd2;
   localparam logic [2:0] ST_SEND_HI = 3'd3;
   localparam logic [2:0] ST_SEND_LO = 3'd4;
   localparam logic [2:0] ST_GAP     = 3'd5;

   localparam int GAP_CYCLES_DEFAULT = 2048;

   // The first byte on the wire is the high byte of each 16-bit word.
   localparam bit HIGH_BYTE_FIRST = 1'b1;

   function automatic logic [7:0] first_byte(input logic [15:0] w);
      return HIGH_BYTE_FIRST ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [7:0] second_byte(input logic [15:0] w);
      return HIGH_BYTE_FIRST ? w[7:0] : w[15:8];
   endfunction

endpackage

// File: rtl/output_process_uart_fifo.sv
// Single-clock 16-bit word FIFO, registered read (q valid one cycle after rdreq),
// asynchronous active-low clear of pointers and fill level.
module uart_tx_fifo #(
   parameter int AW = 7
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wrreq,
   input  logic [15:0]   data,
   input  logic          rdreq,
   output logic [15:0]   q,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   usedw
);

   localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

   logic [15:0]   mem_reg [0:(1<<AW)-1];
   logic [15:0]   q_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   used_reg;
   logic          wr_en;
   logic          rd_en;

   assign empty = (used_reg == '0);
   assign full  = (used_reg == DEPTH);
   assign wr_en = wrreq & ~full;
   assign rd_en = rdreq & ~empty;
   assign usedw = used_reg;
   assign q     = q_reg;

   // Storage and read port carry no reset so they map onto block RAM.
   always_ff @(posedge CLK) begin
      if (wr_en)
         mem_reg[wr_ptr_reg] <= data;
      if (rd_en)
         q_reg <= mem_reg[rd_ptr_reg];
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         used_reg   <= '0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_en)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   used_reg <= used_reg + 1'b1;
            2'b01:   used_reg <= used_reg - 1'b1;
            default: used_reg <= used_reg;
         endcase
      end
   end

endmodule

// File: rtl/output_process_uart.sv
// Serialises FIFO-held 16-bit words to a byte-wide UART transmitter, then holds the
// line idle for a fixed gap so the far end closes the message on its idle timeout.
module output_process_uart
   import output_process_uart_pkg::*;
#(
   parameter int AW         = 7,
   parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT,
   parameter int GAP_W      = 16
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WR_REQ,
   input  logic [15:0]   DATA_IN,
   input  logic          START,
   input  logic [7:0]    MSG_LEN,
   input  logic          PARITY_IN,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW:0]   WR_USED,
   output logic          OVF,
   output logic          ERR_START,
   output logic [2:0]    state_mon
);

   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   logic [2:0]       state_reg;
   logic [15:0]      word_reg;
   logic [7:0]       word_cnt_reg;
   logic             par_reg;
   logic [GAP_W-1:0] gap_cnt_reg;
   logic [7:0]       tx_data_reg;
   logic             tx_valid_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             ovf_reg;
   logic             err_start_reg;

   logic             fifo_rdreq;
   logic [15:0]      fifo_q;
   logic             fifo_empty;
   logic             fifo_full;

   assign fifo_rdreq = (state_reg == ST_POP) && !fifo_empty;

   uart_tx_fifo #(.AW(AW)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .wrreq (WR_REQ),
      .data  (DATA_IN),
      .rdreq (fifo_rdreq),
      .q     (fifo_q),
      .empty (fifo_empty),
      .full  (fifo_full),
      .usedw (WR_USED)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg     <= ST_IDLE;
         word_reg      <= '0;
         word_cnt_reg  <= '0;
         par_reg       <= 1'b0;
         gap_cnt_reg   <= '0;
         tx_data_reg   <= '0;
         tx_valid_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         err_start_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (WR_REQ && fifo_full)
            ovf_reg <= 1'b1;
         if (START && busy_reg)
            err_start_reg <= 1'b1;

         case (state_reg)
            ST_IDLE: begin
               if (START) begin
                  if (MSG_LEN == 8'd0) begin
                     done_reg <= 1'b1;
                  end else begin
                     word_cnt_reg <= MSG_LEN;
                     par_reg      <= PARITY_IN;
                     busy_reg     <= 1'b1;
                     state_reg    <= ST_POP;
                  end
               end
            end
            ST_POP: begin
               // An empty FIFO just stalls here until the writer catches up.
               if (!fifo_empty)
                  state_reg <= ST_LATCH;
            end
            ST_LATCH: begin
               word_reg     <= fifo_q;
               word_cnt_reg <= word_cnt_reg - 8'd1;
               state_reg    <= ST_SEND_HI;
            end
            ST_SEND_HI: begin
               if (!tx_valid_reg) begin
                  tx_valid_reg <= 1'b1;
                  tx_data_reg  <= first_byte(word_reg);
               end else if (tx_ready) begin
                  if (word_cnt_reg == 8'd0 && par_reg) begin
                     tx_valid_reg <= 1'b0;
                     gap_cnt_reg  <= '0;
                     state_reg    <= ST_GAP;
                  end else begin
                     tx_data_reg <= second_byte(word_reg);
                     state_reg   <= ST_SEND_LO;
                  end
               end
            end
            ST_SEND_LO: begin
               if (tx_valid_reg && tx_ready) begin
                  tx_valid_reg <= 1'b0;
                  if (word_cnt_reg != 8'd0) begin
                     state_reg <= ST_POP;
                  end else begin
                     gap_cnt_reg <= '0;
                     state_reg   <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt_reg == GAP_LAST) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign tx_data   = tx_data_reg;
   assign tx_valid  = tx_valid_reg;
   assign BUSY      = busy_reg;
   assign DONE      = done_reg;
   assign OVF       = ovf_reg;
   assign ERR_START = err_start_reg;
   assign state_mon = state_reg;

endmodule

// File: tb/tb_output_process_uart.sv
// Randomised bench for output_process_uart: a word-queue model predicts bytes, DONE
// timing, BUSY and sticky flags every cycle; directed scenarios pin literal values.
module tb_output_process_uart;

   localparam int AW    = 7;
   localparam int DEPTH = 128;
   localparam int GAP   = 2048;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          WR_REQ = 1'b0;
   logic [15:0]   DATA_IN = '0;
   logic          START = 1'b0;
   logic [7:0]    MSG_LEN = '0;
   logic          PARITY_IN = 1'b0;
   logic          tx_ready = 1'b0;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          BUSY;
   logic          DONE;
   logic [AW:0]   WR_USED;
   logic          OVF;
   logic          ERR_START;
   logic [2:0]    state_mon;

   output_process_uart #(.AW(AW), .GAP_CYCLES(GAP), .GAP_W(16)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .WR_REQ    (WR_REQ),
      .DATA_IN   (DATA_IN),
      .START     (START),
      .MSG_LEN   (MSG_LEN),
      .PARITY_IN (PARITY_IN),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .WR_USED   (WR_USED),
      .OVF       (OVF),
      .ERR_START (ERR_START),
      .state_mon (state_mon)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: every accepted word in order, plus the message being sent.
   logic [15:0] wq[$];
   logic [7:0]  cap_q[$];
   bit   m_active = 0, m_busy = 0, m_in_gap = 0, m_par = 0, m_phase_lo = 0;
   bit   m_ovf = 0, m_err = 0;
   int   m_left = 0;
   int   k = 0;
   int   done_due = -1;
   int   last_xfer = -1;
   int   done_seen = -1;
   bit   prev_valid = 0, prev_ready = 0;
   logic [7:0] prev_data = '0;
   int   ready_mode = 0;

   always @(negedge CLK) begin
      bit busy_now;
      logic [7:0] exp_b;
      if (!RST) begin
         wq.delete();
         m_active = 0; m_busy = 0; m_in_gap = 0; m_ovf = 0; m_err = 0;
         done_due = -1; prev_valid = 0; prev_ready = 0;
      end else begin
         k++;
         check("done", DONE, (k == done_due));
         if (DONE) done_seen = k;
         check("busy", BUSY, m_busy);
         check("ovf", OVF, m_ovf);
         check("err_start", ERR_START, m_err);
         if (!m_active) check("valid_outside_msg", tx_valid, 0);
         if (!m_busy) check("wr_used_idle", WR_USED, wq.size());
         if (prev_valid && !prev_ready) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, prev_data);
         end
         busy_now = m_busy;
         if (tx_valid && tx_ready) begin
            if (!m_active || wq.size() == 0) begin
               check("unexpected_byte", tx_valid, 0);
            end else begin
               exp_b = m_phase_lo ? wq[0][7:0] : wq[0][15:8];
               check("tx_byte", tx_data, exp_b);
               cap_q.push_back(tx_data);
               last_xfer = k + 1;
               if (!m_phase_lo && !(m_left == 1 && m_par)) begin
                  m_phase_lo = 1;
               end else begin
                  void'(wq.pop_front());
                  m_left--;
                  m_phase_lo = 0;
                  if (m_left == 0) begin
                     m_active = 0;
                     m_in_gap = 1;
                     done_due = k + 1 + GAP;
                  end
               end
            end
         end
         if (m_in_gap && done_due == k + 1) begin
            m_busy = 0;
            m_in_gap = 0;
         end
         if (START) begin
            if (busy_now) m_err = 1;
            else if (MSG_LEN == 0) done_due = k + 1;
            else begin
               m_busy = 1; m_active = 1; m_left = MSG_LEN;
               m_par = PARITY_IN; m_phase_lo = 0;
            end
         end
         if (WR_REQ) begin
            if (wq.size() >= DEPTH) m_ovf = 1;
            else wq.push_back(DATA_IN);
         end
         prev_valid = tx_valid; prev_ready = tx_ready; prev_data = tx_data;
      end
   end

   // tx_ready: 0 = always ready, 1 = random, 2 = 10 stall cycles per byte, else never.
   initial begin
      int wcnt = 0;
      forever begin
         @(posedge CLK);
         #1;
         case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 9) < 7);
            2: begin
               if (tx_valid && !tx_ready) wcnt++;
               else wcnt = 0;
               tx_ready = (wcnt >= 10);
            end
            default: tx_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [15:0] d);
      WR_REQ = 1'b1; DATA_IN = d;
      tick();
      WR_REQ = 1'b0;
   endtask

   task automatic start(input logic [7:0] len, input logic par);
      START = 1'b1; MSG_LEN = len; PARITY_IN = par;
      tick();
      START = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!DONE && n < budget) begin
         tick();
         n++;
      end
      tests++;
      if (!DONE) begin
         fails++;
         $display("FAIL %s: DONE not seen within %0d cycles", name, budget);
      end
      tick();
   endtask

   task automatic check_bytes(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3, input int n);
      logic [7:0] e[4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      check({name, "_count"}, cap_q.size(), n);
      for (int i = 0; i < n && i < cap_q.size(); i++)
         check($sformatf("%s_byte%0d", name, i), cap_q[i], e[i]);
   endtask

   initial begin
      logic [15:0] fw0, fw1;
      int n;
      #1 RST = 1'b0;
      #2;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_wr_used", WR_USED, 0);
      check("rst_ovf", OVF, 0);
      check("rst_err", ERR_START, 0);
      check("rst_state", state_mon, 0);
      tick(); tick();
      RST = 1'b1;
      tick();

      // 1: basic message, latency and gap length
      ready_mode = 0;
      cap_q.delete();
      wr(16'hA1B2); wr(16'hC3D4);
      start(8'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("latency_lo%0d", i), tx_valid, 0);
         tick();
      end
      check("latency_hi", tx_valid, 1);
      wait_done(6000, "t1_done");
      check_bytes("t1", 8'hA1, 8'hB2, 8'hC3, 8'hD4, 4);
      check("t1_gap_len", done_seen - last_xfer, GAP);

      // 2: stuffing byte suppressed
      cap_q.delete();
      wr(16'h1122); wr(16'h3300);
      start(8'd2, 1'b1);
      wait_done(6000, "t2_done");
      check_bytes("t2", 8'h11, 8'h22, 8'h33, 8'h00, 3);
      check("t2_wr_used", WR_USED, 0);

      // 3: backpressure
      ready_mode = 2;
      cap_q.delete();
      wr(16'h5A6B); wr(16'h7C8D);
      start(8'd2, 1'b0);
      wait_done(6000, "t3_done");
      check_bytes("t3", 8'h5A, 8'h6B, 8'h7C, 8'h8D, 4);

      // 4: underflow stall in POP, resumed by late writes
      ready_mode = 0;
      cap_q.delete();
      wr(16'hDEAD);
      start(8'd3, 1'b0);
      n = 0;
      while (cap_q.size() < 2 && n < 200) begin tick(); n++; end
      repeat (20) tick();
      check("t4_stall_state", state_mon, 1);
      check("t4_stall_valid", tx_valid, 0);
      wr(16'hBEEF); wr(16'h1234);
      wait_done(6000, "t4_done");
      check("t4_count", cap_q.size(), 6);
      if (cap_q.size() == 6) begin
         check("t4_b2", cap_q[2], 8'hBE);
         check("t4_b5", cap_q[5], 8'h34);
      end

      // 5: full FIFO, overflow, START while busy, zero-length START
      fw0 = 16'($urandom); fw1 = 16'($urandom);
      wr(fw0); wr(fw1);
      for (int i = 2; i < DEPTH; i++) wr(16'($urandom));
      check("t5_full_used", WR_USED, DEPTH);
      check("t5_no_ovf", OVF, 0);
      wr(16'hFFFF);
      check("t5_ovf", OVF, 1);
      check("t5_used_after_ovf", WR_USED, DEPTH);
      cap_q.delete();
      start(8'd2, 1'b0);
      repeat (5) tick();
      start(8'd1, 1'b0);
      check("t5_err_start", ERR_START, 1);
      wait_done(6000, "t5_done");
      check_bytes("t5", fw0[15:8], fw0[7:0], fw1[15:8], fw1[7:0], 4);
      cap_q.delete();
      start(8'd126, 1'b0);
      wait_done(8000, "t5_drain_done");
      check("t5_drain_count", cap_q.size(), 252);
      check("t5_drain_used", WR_USED, 0);
      start(8'd0, 1'b0);
      check("t5_zero_done", DONE, 1);
      check("t5_zero_busy", BUSY, 0);
      tick();
      check("t5_zero_done_pulse", DONE, 0);
      check("t5_zero_valid", tx_valid, 0);

      // randomised messages, some words written after START
      ready_mode = 1;
      for (int m = 0; m < 8; m++) begin
         int len, pre;
         bit par;
         len = $urandom_range(1, 8);
         par = 1'($urandom_range(0, 1));
         pre = $urandom_range(0, len);
         cap_q.delete();
         for (int i = 0; i < pre; i++) begin
            wr(16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
         end
         start(8'(len), par);
         for (int i = pre; i < len; i++) begin
            repeat ($urandom_range(0, 6)) tick();
            wr(16'($urandom));
         end
         wait_done(8000, $sformatf("rnd%0d_done", m));
         check($sformatf("rnd%0d_count", m), cap_q.size(), 2 * len - int'(par));
      end

      // 6: reset while holding the low byte
      ready_mode = 2;
      wr(16'h55AA); wr(16'h66BB);
      start(8'd2, 1'b0);
      n = 0;
      while (state_mon != 3'd4 && n < 100) begin tick(); n++; end
      check("t6_in_send_lo", state_mon, 4);
      #1 RST = 1'b0;
      #1;
      check("t6_rst_valid", tx_valid, 0);
      check("t6_rst_used", WR_USED, 0);
      check("t6_rst_busy", BUSY, 0);
      tick(); tick();
      RST = 1'b1;
      tick();
      check("t6_state_idle", state_mon, 0);
      check("t6_valid_idle", tx_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
